// File: rtl/apb_req_master_if.sv
// Request/response port plus APB3 master-side signals for apb_req_master.
// The master modport is the initiator view; slave is the core/peripheral view.
interface apb_req_master_if #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32
);
  logic                      req_valid;
  logic                      req_ready;
  logic [APB_ADDR_WIDTH-1:0] req_addr;
  logic                      req_we;
  logic [APB_DATA_WIDTH-1:0] req_wdata;
  logic                      resp_valid;
  logic [APB_DATA_WIDTH-1:0] resp_rdata;
  logic                      resp_err;
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [APB_DATA_WIDTH-1:0] pwdata;
  logic                      pwrite;
  logic                      psel;
  logic                      penable;
  logic [APB_DATA_WIDTH-1:0] prdata;
  logic                      pready;
  logic                      pslverr;

  modport master (
    input  req_valid,
    input  req_addr,
    input  req_we,
    input  req_wdata,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err,
    output paddr,
    output pwdata,
    output pwrite,
    output psel,
    output penable,
    input  prdata,
    input  pready,
    input  pslverr
  );

  modport slave (
    output req_valid,
    output req_addr,
    output req_we,
    output req_wdata,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err,
    input  paddr,
    input  pwdata,
    input  pwrite,
    input  psel,
    input  penable,
    output prdata,
    output pready,
    output pslverr
  );
endinterface

// File: rtl/apb_req_master.sv
// APB3 initiator: single-outstanding valid/ready request to SETUP/ACCESS
// transfers, with a bounded PREADY wait and a one-cycle response pulse.
module apb_req_master #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  apb_req_master_if.master  bus
);

  localparam int unsigned CNT_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  state_e                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      to_hit;

  assign to_hit = TO_EN && (cnt_q == TO_LAST);

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        rdata_d = '0;
        err_d   = 1'b0;
        cnt_d   = '0;
        if (bus.req_valid) begin
          paddr_d  = bus.req_addr;
          pwrite_d = bus.req_we;
          pwdata_d = bus.req_wdata;
          // misaligned requests never reach the bus
          if (bus.req_addr[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (bus.pready) begin
          rdata_d = pwrite_q ? '0 : bus.prdata;
          err_d   = bus.pslverr;
          state_d = RESP;
        end else if (to_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        rdata_d = '0;
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // bus strobes decode the state register only, never pready
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.psel       = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.penable    = (state_q == ACCESS);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.paddr      = paddr_q;
  assign bus.pwdata     = pwdata_q;
  assign bus.pwrite     = pwrite_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Scoreboard bench for apb_req_master: random requests, an APB slave
// model with programmable wait states, and a response monitor.
module tb_apb_req_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_req_master_if #(
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW)
  ) bus ();

  apb_req_master #(
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          waits;
    logic        slverr;
    logic [31:0] rdata;
  } sl_t;

  exp_t sb[$];
  sl_t  slq[$];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: response content and arrival cycle from the request alone
  function automatic exp_t model(input logic [31:0] addr,
                                 input logic we,
                                 input int waits,
                                 input logic slverr,
                                 input logic [31:0] rdata,
                                 input int acc);
    exp_t e;
    if (addr[1:0] != 2'b00) begin
      e.rdata = 0; e.err = 1'b1; e.due = acc + 1;
    end else if (TO != 0 && waits >= TO) begin
      e.rdata = 0; e.err = 1'b1; e.due = acc + 2 + TO;
    end else begin
      e.rdata = we ? 32'h0 : rdata;
      e.err   = slverr;
      e.due   = acc + 3 + waits;
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after acceptance
  task automatic issue(input logic [31:0] addr, input logic we,
                       input logic [31:0] wdata, input int waits,
                       input logic slverr, input logic [31:0] rdata,
                       input bit track, output int acc);
    sl_t s;
    int t;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_we    = we;
    bus.req_wdata = wdata;
    t = 0;
    while (!bus.req_ready && t < 60) begin
      @(negedge clk);
      t++;
    end
    acc = cyc;
    if (!bus.req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1");
      bus.req_valid = 1'b0;
      return;
    end
    if (addr[1:0] == 2'b00) begin
      s.addr = addr; s.we = we; s.wdata = wdata;
      s.waits = waits; s.slverr = slverr; s.rdata = rdata;
      slq.push_back(s);
    end
    if (track) sb.push_back(model(addr, we, waits, slverr, rdata, acc));
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_we    = 1'($urandom);
    bus.req_wdata = $urandom;
  endtask

  // APB slave model; drives junk outside ACCESS
  int acc_n = 0;
  bit was_acc = 0;
  always @(negedge clk) begin
    if (bus.psel && bus.penable) begin
      if (slq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_access: got psel=1 expected 0");
      end else begin
        chk("acc_paddr", bus.paddr, slq[0].addr);
        chk("acc_pwrite", bus.pwrite, slq[0].we);
        chk("acc_pwdata", bus.pwdata, slq[0].wdata);
        bus.pready  = (acc_n == slq[0].waits);
        bus.pslverr = bus.pready ? slq[0].slverr : 1'($urandom);
        bus.prdata  = bus.pready ? slq[0].rdata : $urandom;
      end
      acc_n++;
      was_acc = 1;
    end else begin
      if (bus.psel) begin
        if (slq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_setup: got psel=1 expected 0");
        end else begin
          chk("setup_paddr", bus.paddr, slq[0].addr);
          chk("setup_pwdata", bus.pwdata, slq[0].wdata);
        end
      end
      if (was_acc && slq.size() > 0) void'(slq.pop_front());
      was_acc = 0;
      acc_n = 0;
      bus.pready  = 1'($urandom);
      bus.pslverr = 1'($urandom);
      bus.prdata  = $urandom;
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.resp_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected 0");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_rdata", bus.resp_rdata, e.rdata);
          chk("resp_err", bus.resp_err, e.err);
          chk("resp_cycle", cyc, e.due);
          chk("resp_ready_low", bus.req_ready, 1'b0);
        end
      end else begin
        chk("idle_rdata", bus.resp_rdata, 0);
        chk("idle_err", bus.resp_err, 0);
      end
    end
  end

  int a0, a1, t;
  logic [31:0] ad;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_we    = 1'b0;
    bus.req_wdata = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    bus.prdata    = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.req_ready, 1'b1);
    chk("rst_psel", bus.psel, 1'b0);
    chk("rst_penable", bus.penable, 1'b0);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_pwdata", bus.pwdata, 0);
    chk("rst_pwrite", bus.pwrite, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    issue(32'h1A10_1000, 1'b0, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 1, a0);
    issue(32'h1A10_3004, 1'b1, 32'hA5, 4, 1'b0, 32'h1234_5678, 1, a0);
    issue(32'h1A10_2008, 1'b0, 32'h0, 1, 1'b1, 32'hDEAD_BEEF, 1, a0);
    issue(32'h1A10_4000, 1'b0, 32'h0, 20, 1'b0, 32'h5555_AAAA, 1, a0);
    issue(32'h1A10_400C, 1'b0, 32'h0, 7, 1'b0, 32'h0BAD_F00D, 1, a0);
    issue(32'h1A10_0002, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1, a0);
    issue(32'h1A10_0010, 1'b1, 32'hCAFE, 0, 1'b0, 32'h0, 1, a0);
    issue(32'h1A10_0014, 1'b0, 32'h0, 0, 1'b0, 32'h77, 1, a1);
    chk("throughput", a1 - a0, 4);

    for (int i = 0; i < 80; i++) begin
      ad = $urandom;
      if ($urandom_range(0, 5) != 0) ad[1:0] = 2'b00;
      issue(ad, 1'($urandom), $urandom, int'($urandom_range(0, 10)),
            1'($urandom_range(0, 3) == 0), $urandom, 1, a0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // reset during ACCESS with a new request pending
    issue(32'h1A10_5000, 1'b0, 32'h0, 6, 1'b0, 32'h1, 0, a0);
    t = 0;
    while (!(bus.psel && bus.penable) && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("rst_mid_reached_access", bus.penable, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h1A10_6000;
    @(negedge clk);
    chk("rst_mid_psel", bus.psel, 1'b0);
    chk("rst_mid_penable", bus.penable, 1'b0);
    chk("rst_mid_resp", bus.resp_valid, 1'b0);
    chk("rst_mid_ready", bus.req_ready, 1'b1);
    bus.req_valid = 1'b0;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_mid_no_reissue", bus.psel, 1'b0);
    issue(32'h1A10_7000, 1'b0, 32'h0, 2, 1'b0, 32'hFEED_0001, 1, a0);

    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
